// File: rtl/demux1to2_buffered.sv
// Buffered 1-to-2 valid/ready demultiplexer with one FIFO per output.
// Optional pop counters are enabled by defining DEMUX_ROUTE_COUNT_EN.
module demux1to2_buffered #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_select,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready
`ifdef DEMUX_ROUTE_COUNT_EN
   ,
   output logic [15:0]      out0_count,
   output logic [15:0]      out1_count
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q [2];
   logic [AW:0]      wptr_d [2];
   logic [AW:0]      rptr_q [2];
   logic [AW:0]      rptr_d [2];
   logic [WIDTH-1:0] mem_q  [2][DEPTH];

   logic [1:0] empty;
   logic [1:0] full;
   logic [1:0] push;
   logic [1:0] pop;
   logic [1:0] out_rdy;

   assign out_rdy = {out1_ready, out0_ready};

   // Occupancy flags, handshakes and next pointer values.
   always_comb begin
      empty    = '0;
      full     = '0;
      push     = '0;
      pop      = '0;
      in_ready = 1'b0;
      for (int s = 0; s < 2; s++) begin
         empty[s] = (wptr_q[s] == rptr_q[s]);
         full[s]  = (wptr_q[s][AW-1:0] == rptr_q[s][AW-1:0]) &&
                    (wptr_q[s][AW] != rptr_q[s][AW]);
      end
      // Held low in reset; never looks at the consumer readies.
      in_ready = rst_n && !full[in_select];
      if (in_valid && in_ready) begin
         push[in_select] = 1'b1;
      end
      for (int s = 0; s < 2; s++) begin
         pop[s]    = !empty[s] && out_rdy[s];
         wptr_d[s] = wptr_q[s] + {{AW{1'b0}}, push[s]};
         rptr_d[s] = rptr_q[s] + {{AW{1'b0}}, pop[s]};
      end
   end

   // Pointer registers; reset empties both FIFOs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 2; s++) begin
            wptr_q[s] <= '0;
            rptr_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            wptr_q[s] <= wptr_d[s];
            rptr_q[s] <= rptr_d[s];
         end
      end
   end

   // Storage write; contents are meaningless until a pointer covers them.
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push[s]) begin
            mem_q[s][wptr_q[s][AW-1:0]] <= in_data;
         end
      end
   end

   assign out0_valid = !empty[0];
   assign out1_valid = !empty[1];
   assign out0_data  = mem_q[0][rptr_q[0][AW-1:0]];
   assign out1_data  = mem_q[1][rptr_q[1][AW-1:0]];

`ifdef DEMUX_ROUTE_COUNT_EN
   logic [15:0] cnt_q [2];
   logic [15:0] cnt_d [2];

   // Free-running pop counters with natural 16-bit wrap.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         cnt_d[s] = cnt_q[s] + {15'd0, pop[s]};
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
      end
   end

   assign out0_count = cnt_q[0];
   assign out1_count = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux1to2_buffered.sv
// Directed bench for demux1to2_buffered (WIDTH=32, DEPTH=2).
// Counter checks are compiled in when DEMUX_ROUTE_COUNT_EN is defined.
module tb_demux1to2_buffered;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_select;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out0_data;
   logic        out0_valid;
   logic        out0_ready;
   logic [31:0] out1_data;
   logic        out1_valid;
   logic        out1_ready;
`ifdef DEMUX_ROUTE_COUNT_EN
   logic [15:0] out0_count;
   logic [15:0] out1_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   demux1to2_buffered #(.WIDTH(32), .DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_select  (in_select),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready)
`ifdef DEMUX_ROUTE_COUNT_EN
      ,
      .out0_count (out0_count),
      .out1_count (out1_count)
`endif
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          sent;
      int          rcvd;
      int          occ;
      int          cyc;
      logic        acc;
      logic        pp;
      logic [31:0] lfsr;

      rst_n      = 1'b0;
      in_data    = '0;
      in_select  = 1'b0;
      in_valid   = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;

      // Reset held for 3 cycles.
      #3;
      for (int i = 0; i < 3; i++) begin
         chk("rst_v0", {31'd0, out0_valid}, 32'd0);
         chk("rst_v1", {31'd0, out1_valid}, 32'd0);
         chk("rst_ir", {31'd0, in_ready}, 32'd0);
         tick();
      end
      rst_n = 1'b1;
      #1;
      chk("rel_ir", {31'd0, in_ready}, 32'd1);
      chk("rel_v0", {31'd0, out0_valid}, 32'd0);

      // Routing and 1-cycle latency.
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      in_valid   = 1'b1;
      in_select  = 1'b0;
      in_data    = 32'hA5A5_0001;
      #1;
      chk("rt_ir0", {31'd0, in_ready}, 32'd1);
      tick();
      chk("rt_v0", {31'd0, out0_valid}, 32'd1);
      chk("rt_d0", out0_data, 32'hA5A5_0001);
      chk("rt_v1a", {31'd0, out1_valid}, 32'd0);
      in_select = 1'b1;
      in_data   = 32'h5A5A_0002;
      tick();
      chk("rt_v0off", {31'd0, out0_valid}, 32'd0);
      chk("rt_v1", {31'd0, out1_valid}, 32'd1);
      chk("rt_d1", out1_data, 32'h5A5A_0002);
      in_valid = 1'b0;
      tick();
      chk("rt_v1off", {31'd0, out1_valid}, 32'd0);

      // Fill FIFO0 while its consumer stalls.
      out0_ready = 1'b0;
      out1_ready = 1'b1;
      in_valid   = 1'b1;
      in_select  = 1'b0;
      in_data    = 32'h0000_0101;
      tick();
      chk("fl_ir1", {31'd0, in_ready}, 32'd1);
      in_data = 32'h0000_0102;
      tick();
      in_data = 32'h0000_0103;
      #1;
      chk("fl_full", {31'd0, in_ready}, 32'd0);
      tick();
      chk("fl_head", out0_data, 32'h0000_0101);
      chk("fl_ir2", {31'd0, in_ready}, 32'd0);
      // The other side still accepts.
      in_select = 1'b1;
      in_data   = 32'h0000_0204;
      #1;
      chk("iso_ir", {31'd0, in_ready}, 32'd1);
      tick();
      chk("iso_v1", {31'd0, out1_valid}, 32'd1);
      chk("iso_d1", out1_data, 32'h0000_0204);
      // Full FIFO0 popping this cycle still refuses the push.
      in_select  = 1'b0;
      in_data    = 32'h0000_0103;
      out0_ready = 1'b1;
      #1;
      chk("fp_ir", {31'd0, in_ready}, 32'd0);
      tick();
      chk("fp_v1off", {31'd0, out1_valid}, 32'd0);
      chk("fp_d2", out0_data, 32'h0000_0102);
      chk("fp_ir2", {31'd0, in_ready}, 32'd1);
      tick();
      chk("fp_d3", out0_data, 32'h0000_0103);
      chk("fp_v3", {31'd0, out0_valid}, 32'd1);
      in_valid = 1'b0;
      tick();
      chk("fp_empty", {31'd0, out0_valid}, 32'd0);

      // Wrap-around stream with pseudo-random backpressure.
      lfsr = 32'hACE1_1234;
      sent = 0;
      rcvd = 0;
      occ  = 0;
      cyc  = 0;
      in_select = 1'b0;
      while (rcvd < 20 && cyc < 300) begin
         lfsr       = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
         out0_ready = lfsr[3];
         in_valid   = (sent < 20);
         in_data    = sent;
         #1;
         chk("wr_ir", {31'd0, in_ready}, {31'd0, occ < 2});
         chk("wr_v", {31'd0, out0_valid}, {31'd0, occ > 0});
         acc = in_valid && in_ready;
         pp  = out0_valid && out0_ready;
         if (pp) begin
            chk("wr_data", out0_data, rcvd);
            rcvd++;
         end
         if (acc) sent++;
         occ = occ + int'(acc) - int'(pp);
         tick();
         cyc++;
      end
      chk("wr_done", rcvd, 32'd20);
      in_valid = 1'b0;

      // Asynchronous reset in the middle of a cycle.
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      in_valid   = 1'b1;
      in_select  = 1'b0;
      in_data    = 32'hDEAD_0001;
      tick();
      in_data = 32'hDEAD_0002;
      tick();
      in_select = 1'b1;
      in_data   = 32'hDEAD_0003;
      tick();
      in_valid = 1'b0;
      chk("mr_v0", {31'd0, out0_valid}, 32'd1);
      chk("mr_v1", {31'd0, out1_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_v0off", {31'd0, out0_valid}, 32'd0);
      chk("mr_v1off", {31'd0, out1_valid}, 32'd0);
      chk("mr_ir", {31'd0, in_ready}, 32'd0);
      tick();
      #3;
      rst_n      = 1'b1;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mr_stale0", {31'd0, out0_valid}, 32'd0);
         chk("mr_stale1", {31'd0, out1_valid}, 32'd0);
      end

`ifdef DEMUX_ROUTE_COUNT_EN
      chk("ct_rst0", {16'd0, out0_count}, 32'd0);
      chk("ct_rst1", {16'd0, out1_count}, 32'd0);
      in_valid  = 1'b1;
      in_select = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'hC000_0000 + i;
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      chk("ct_three", {16'd0, out1_count}, 32'd3);
      chk("ct_other", {16'd0, out0_count}, 32'd0);
      // Bring the count to 0xFFFF, then one more pop wraps it.
      sent     = 3;
      cyc      = 0;
      in_valid = 1'b1;
      while (sent < 65535 && cyc < 70000) begin
         #1;
         if (in_ready) sent++;
         if (sent == 65535) in_valid = 1'b0;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("ct_max", {16'd0, out1_count}, 32'h0000_FFFF);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("ct_wrap", {16'd0, out1_count}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
